// File: rtl/ain_spike_encoder_pkg.sv
// Shared definitions for the analog-input spike encoder: FSM state
// encodings, the system mode that enables acquisition, and the special
// ain_state codes produced by the ADC averaging front end.
package ain_spike_encoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_ENCODE  = 3'd2,
        ST_DONE    = 3'd3,
        ST_WAIT    = 3'd4
    } enc_state_t;

    // system_state value in which capture and encoding are allowed
    localparam logic [2:0] RUN_STATE = 3'd1;

    // ain_state codes: front end idle, and all channels finished
    localparam logic [3:0] AIN_IDLE = 4'd0;
    localparam logic [3:0] AIN_END  = 4'd5;

endpackage

// File: rtl/ain_spike_encoder_if_neuron.sv
// Integrate-and-fire neuron for one channel. Each step adds the channel
// value to an AW-bit accumulator; the carry out of that add is the spike.
// The accumulator wraps instead of saturating, which yields exactly
// floor(steps*ch/2^AW) spikes over a window.
module ain_if_neuron
    import ain_spike_encoder_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          step,
    input  logic [AW-1:0] ch,
    output logic          spike
);

    logic [AW-1:0] acc;
    logic [AW:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, ch};

    // Accumulate on each step and latch the carry as the spike bit
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc   <= '0;
            spike <= 1'b0;
        end else if (step) begin
            acc   <= sum[AW-1:0];
            spike <= sum[AW];
        end
    end

endmodule

// File: rtl/ain_spike_encoder.sv
// Captures the per-channel ADC averages as the front end steps through its
// channels, then rate-codes them into spike trains over T_STEPS steps of
// STEP_CYCLES clocks each. Dropping key_state or leaving system mode 1
// aborts back to IDLE at any point; captured values are kept.
// Optional build macro SPIKE_COUNT_EN adds per-channel spike counters on
// output spike_cnt.
module ain_spike_encoder
    import ain_spike_encoder_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int AW          = 12,
    parameter int T_STEPS     = 64,
    parameter int STEP_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_state,
    input  logic [2:0]           system_state,
    input  logic [3:0]           ain_state,
    input  logic [AW-1:0]        ain_ave,
    output logic [N_CH-1:0]      spike_out,
    output logic                 spike_valid,
    output logic [5:0]           step_idx,
    output logic                 enc_busy,
    output logic                 enc_done,
    output logic [N_CH*AW-1:0]   ch_val
`ifdef SPIKE_COUNT_EN
    ,
    output logic [N_CH*7-1:0]    spike_cnt
`endif
);

    localparam int            CW        = $clog2(STEP_CYCLES);
    localparam logic [CW-1:0] CYC_LAST  = CW'(STEP_CYCLES - 1);
    localparam logic [5:0]    LAST_STEP = 6'(T_STEPS - 1);

    enc_state_t                   state;
    enc_state_t                   next_state;
    logic                         run;
    logic [3:0]                   ain_state_d;
    logic                         chan_valid;
    logic [N_CH-1:0][AW-1:0]      ch_reg;
    logic [N_CH-1:0]              cap_flag;
    logic [CW-1:0]                cyc_cnt;
    logic                         enc_entry;
    logic                         step_fire;
    logic                         neuron_clr;

    assign run        = key_state && (system_state == RUN_STATE);
    assign ch_val     = ch_reg;
    assign neuron_clr = !run || (state == ST_IDLE) || enc_entry;
    assign chan_valid = (ain_state != ain_state_d) &&
                        (ain_state_d != AIN_IDLE) &&
                        (ain_state_d != AIN_END) &&
                        (ain_state_d <= 4'(N_CH));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus the state-decoded strobes and flags
    always_comb begin
        next_state = state;
        enc_busy   = (state == ST_ENCODE);
        enc_done   = (state == ST_DONE);
        enc_entry  = 1'b0;
        step_fire  = (state == ST_ENCODE) && run && (cyc_cnt == CYC_LAST);
        if (!run) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    next_state = ST_CAPTURE;
                ST_CAPTURE: begin
                    if (&cap_flag) begin
                        next_state = ST_ENCODE;
                        enc_entry  = 1'b1;
                    end
                end
                ST_ENCODE: begin
                    if (spike_valid && (step_idx == LAST_STEP)) begin
                        next_state = ST_DONE;
                    end
                end
                ST_DONE:    next_state = ST_WAIT;
                ST_WAIT: begin
                    if (ain_state == AIN_IDLE) begin
                        next_state = ST_IDLE;
                    end
                end
                default:    next_state = ST_IDLE;
            endcase
        end
    end

    // One-cycle delayed channel index, used to detect the index advancing
    always_ff @(posedge clk) begin
        if (rst) begin
            ain_state_d <= AIN_IDLE;
        end else begin
            ain_state_d <= ain_state;
        end
    end

    // Latch the finished channel's average while capturing; flags reset on abort/idle
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_reg   <= '0;
            cap_flag <= '0;
        end else if (!run || (state == ST_IDLE)) begin
            cap_flag <= '0;
        end else if ((state == ST_CAPTURE) && chan_valid) begin
            for (int i = 0; i < N_CH; i++) begin
                if (ain_state_d == 4'(i + 1)) begin
                    ch_reg[i]   <= ain_ave;
                    cap_flag[i] <= 1'b1;
                end
            end
        end
    end

    // Step timing: cycle counter, step index and the spike_valid strobe
    always_ff @(posedge clk) begin
        if (rst || !run || (state == ST_IDLE)) begin
            cyc_cnt     <= '0;
            step_idx    <= '0;
            spike_valid <= 1'b0;
        end else begin
            spike_valid <= step_fire;
            if (enc_entry) begin
                cyc_cnt  <= '0;
                step_idx <= '0;
            end else if (state == ST_ENCODE) begin
                cyc_cnt <= (cyc_cnt == CYC_LAST) ? '0 : cyc_cnt + CW'(1);
                if (spike_valid && (step_idx != LAST_STEP)) begin
                    step_idx <= step_idx + 6'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_neuron
        ain_if_neuron #(
            .AW(AW)
        ) u_neuron (
            .clk  (clk),
            .rst  (rst),
            .clr  (neuron_clr),
            .step (step_fire),
            .ch   (ch_reg[g]),
            .spike(spike_out[g])
        );
    end

`ifdef SPIKE_COUNT_EN
    logic [N_CH-1:0][6:0] cnt_reg;

    assign spike_cnt = cnt_reg;

    // Count emitted spikes per channel; cleared only when a new window starts
    always_ff @(posedge clk) begin
        if (rst || enc_entry) begin
            cnt_reg <= '0;
        end else if (spike_valid) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_reg[i] <= cnt_reg[i] + 7'(spike_out[i]);
            end
        end
    end
`endif

endmodule

// File: tb/tb_ain_spike_encoder.sv
// Directed bench for ain_spike_encoder: reset, capture, rate-coded spike
// pattern, abort/reacquire, spurious index changes and mid-encode reset.
module tb_ain_spike_encoder;

    localparam int T_STEPS = 64;
    localparam int STEP_CYCLES = 16;
    localparam logic [47:0] EXP_CH_A = {12'd0, 12'd4095, 12'd1024, 12'd2048};
    localparam logic [47:0] EXP_CH_B = {12'd4000, 12'd300, 12'd200, 12'd100};

    logic        clk = 1'b0;
    logic        rst;
    logic        key_state;
    logic [2:0]  system_state;
    logic [3:0]  ain_state;
    logic [11:0] ain_ave;
    logic [3:0]  spike_out;
    logic        spike_valid;
    logic [5:0]  step_idx;
    logic        enc_busy;
    logic        enc_done;
    logic [47:0] ch_val;
`ifdef SPIKE_COUNT_EN
    logic [27:0] spike_cnt;
`endif

    int total = 0;
    int bad   = 0;

    ain_spike_encoder dut (
        .clk         (clk),
        .rst         (rst),
        .key_state   (key_state),
        .system_state(system_state),
        .ain_state   (ain_state),
        .ain_ave     (ain_ave),
        .spike_out   (spike_out),
        .spike_valid (spike_valid),
        .step_idx    (step_idx),
        .enc_busy    (enc_busy),
        .enc_done    (enc_done),
        .ch_val      (ch_val)
`ifdef SPIKE_COUNT_EN
        ,
        .spike_cnt   (spike_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Hand-derived spike pattern for channel values {0,4095,1024,2048}
    function automatic logic [3:0] exp_pattern(input int k);
        logic [3:0] p;
        p[0] = (k % 2 == 1);
        p[1] = (k % 4 == 3);
        p[2] = (k >= 1);
        p[3] = 1'b0;
        return p;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Walk ain_state 1..5; each increment carries the previous channel's average
    task automatic acquire(input logic [11:0] v0, v1, v2, v3);
        ain_state = 4'd1; ain_ave = 12'd0; tick(1);
        ain_state = 4'd2; ain_ave = v0;    tick(1);
        ain_state = 4'd3; ain_ave = v1;    tick(1);
        ain_state = 4'd4; ain_ave = v2;    tick(1);
        ain_state = 4'd5; ain_ave = v3;
    endtask

    task automatic check_entry(input logic [47:0] exp_ch, input string tag);
        tick(1);
        total++;
        if (enc_busy !== 1'b0) begin
            bad++; $display("[TB] FAIL %s_early_busy got=%b want=0", tag, enc_busy);
        end
        total++;
        if (ch_val !== exp_ch) begin
            bad++; $display("[TB] FAIL %s_ch_val got=%h want=%h", tag, ch_val, exp_ch);
        end
        tick(1);
        total++;
        if (enc_busy !== 1'b1) begin
            bad++; $display("[TB] FAIL %s_entry_busy got=%b want=1", tag, enc_busy);
        end
        total++;
        if (step_idx !== 6'd0) begin
            bad++; $display("[TB] FAIL %s_entry_step got=%0d want=0", tag, step_idx);
        end
`ifdef SPIKE_COUNT_EN
        total++;
        if (spike_cnt !== 28'd0) begin
            bad++; $display("[TB] FAIL %s_cnt_clear got=%h want=0", tag, spike_cnt);
        end
`endif
    endtask

    task automatic run_window(input int n, input string tag);
        logic [3:0] last;
        logic       gap_bad;
        int         cnt[4];
        int         first[4];
        int         exp_cnt[4];
        int         exp_first[4];
        exp_cnt   = '{32, 16, 63, 0};
        exp_first = '{1, 3, 1, -1};
        last = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            cnt[i] = 0; first[i] = -1;
        end
        for (int k = 0; k < n; k++) begin
            gap_bad = 1'b0;
            for (int j = 1; j <= STEP_CYCLES; j++) begin
                tick(1);
                if (j < STEP_CYCLES) begin
                    if (spike_valid !== 1'b0) gap_bad = 1'b1;
                    if (j == 8) begin
                        total++;
                        if (spike_out !== last) begin
                            bad++;
                            $display("[TB] FAIL %s_hold step=%0d got=%b want=%b", tag, k, spike_out, last);
                        end
                    end
                end
            end
            total++;
            if (gap_bad) begin
                bad++; $display("[TB] FAIL %s_period step=%0d got=early_strobe want=none", tag, k);
            end
            total++;
            if (spike_valid !== 1'b1) begin
                bad++; $display("[TB] FAIL %s_strobe step=%0d got=%b want=1", tag, k, spike_valid);
            end
            total++;
            if (step_idx !== 6'(k)) begin
                bad++; $display("[TB] FAIL %s_step_idx got=%0d want=%0d", tag, step_idx, k);
            end
            total++;
            if (spike_out !== exp_pattern(k)) begin
                bad++; $display("[TB] FAIL %s_spikes step=%0d got=%b want=%b", tag, k, spike_out, exp_pattern(k));
            end
            last = exp_pattern(k);
            for (int i = 0; i < 4; i++) begin
                if (spike_out[i] === 1'b1) begin
                    cnt[i]++;
                    if (first[i] < 0) first[i] = k;
                end
            end
        end
        if (n == T_STEPS) begin
            tick(1);
            total++;
            if (enc_done !== 1'b1) begin
                bad++; $display("[TB] FAIL %s_done got=%b want=1", tag, enc_done);
            end
            total++;
            if (spike_valid !== 1'b0 || enc_busy !== 1'b0) begin
                bad++; $display("[TB] FAIL %s_done_flags got=%b%b want=00", tag, spike_valid, enc_busy);
            end
            tick(1);
            total++;
            if (enc_done !== 1'b0) begin
                bad++; $display("[TB] FAIL %s_done_pulse got=%b want=0", tag, enc_done);
            end
            for (int i = 0; i < 4; i++) begin
                total++;
                if (cnt[i] != exp_cnt[i]) begin
                    bad++; $display("[TB] FAIL %s_count ch%0d got=%0d want=%0d", tag, i, cnt[i], exp_cnt[i]);
                end
                total++;
                if (first[i] != exp_first[i]) begin
                    bad++; $display("[TB] FAIL %s_first ch%0d got=%0d want=%0d", tag, i, first[i], exp_first[i]);
                end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; key_state = 1'b1; system_state = 3'd1;
        ain_state = 4'd0; ain_ave = 12'd0;
        tick(2);
        total++;
        if ({spike_out, spike_valid, step_idx, enc_busy, enc_done} !== 13'd0) begin
            bad++; $display("[TB] FAIL reset_outputs got=%h want=0", {spike_out, spike_valid, step_idx, enc_busy, enc_done});
        end
        total++;
        if (ch_val !== 48'd0) begin
            bad++; $display("[TB] FAIL reset_ch_val got=%h want=0", ch_val);
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_rate_coding;
        acquire(12'd2048, 12'd1024, 12'd4095, 12'd0);
        check_entry(EXP_CH_A, "capture");
        run_window(T_STEPS, "rate");
`ifdef SPIKE_COUNT_EN
        total++;
        if (spike_cnt !== {7'd0, 7'd63, 7'd16, 7'd32}) begin
            bad++; $display("[TB] FAIL spike_cnt got=%h want=%h", spike_cnt, {7'd0, 7'd63, 7'd16, 7'd32});
        end
`endif
    endtask

    task automatic test_abort;
        ain_state = 4'd0;
        tick(2);
`ifdef SPIKE_COUNT_EN
        total++;
        if (spike_cnt !== {7'd0, 7'd63, 7'd16, 7'd32}) begin
            bad++; $display("[TB] FAIL spike_cnt_hold got=%h want=%h", spike_cnt, {7'd0, 7'd63, 7'd16, 7'd32});
        end
`endif
        acquire(12'd2048, 12'd1024, 12'd4095, 12'd0);
        check_entry(EXP_CH_A, "abort_pre");
        run_window(21, "abort_pre");
        key_state = 1'b0;
        ain_state = 4'd0;
        tick(1);
        total++;
        if (enc_busy !== 1'b0 || spike_valid !== 1'b0 || enc_done !== 1'b0) begin
            bad++; $display("[TB] FAIL abort_flags got=%b%b%b want=000", enc_busy, spike_valid, enc_done);
        end
        total++;
        if (spike_out !== 4'd0) begin
            bad++; $display("[TB] FAIL abort_spikes got=%b want=0000", spike_out);
        end
        total++;
        if (step_idx !== 6'd0) begin
            bad++; $display("[TB] FAIL abort_step got=%0d want=0", step_idx);
        end
        total++;
        if (ch_val !== EXP_CH_A) begin
            bad++; $display("[TB] FAIL abort_ch_hold got=%h want=%h", ch_val, EXP_CH_A);
        end
        tick(1);
        key_state = 1'b1;
        tick(2);
        acquire(12'd2048, 12'd1024, 12'd4095, 12'd0);
        check_entry(EXP_CH_A, "reacq");
        run_window(T_STEPS, "reacq");
    endtask

    task automatic test_spurious;
        logic busy_seen;
        ain_state = 4'd0;
        tick(2);
        ain_state = 4'd5; tick(1);
        ain_state = 4'd0; tick(1);
        busy_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (enc_busy !== 1'b0 || spike_valid !== 1'b0) busy_seen = 1'b1;
        end
        total++;
        if (busy_seen) begin
            bad++; $display("[TB] FAIL spurious_capture got=encode want=capture");
        end
        acquire(12'd100, 12'd200, 12'd300, 12'd4000);
        check_entry(EXP_CH_B, "second");
    endtask

    task automatic test_reset_mid_encode;
        logic busy_seen;
        tick(40);
        rst = 1'b1;
        tick(2);
        total++;
        if ({spike_out, spike_valid, step_idx, enc_busy, enc_done} !== 13'd0) begin
            bad++; $display("[TB] FAIL midreset_outputs got=%h want=0", {spike_out, spike_valid, step_idx, enc_busy, enc_done});
        end
        total++;
        if (ch_val !== 48'd0) begin
            bad++; $display("[TB] FAIL midreset_ch_val got=%h want=0", ch_val);
        end
`ifdef SPIKE_COUNT_EN
        total++;
        if (spike_cnt !== 28'd0) begin
            bad++; $display("[TB] FAIL midreset_cnt got=%h want=0", spike_cnt);
        end
`endif
        rst = 1'b0;
        busy_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (enc_busy !== 1'b0 || spike_valid !== 1'b0) busy_seen = 1'b1;
        end
        total++;
        if (busy_seen) begin
            bad++; $display("[TB] FAIL midreset_idle got=encode want=no_encode");
        end
    endtask

    initial begin
        test_reset();
        test_rate_coding();
        test_abort();
        test_spurious();
        test_reset_mid_encode();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Bound on total run time in case the design stalls
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
